pc_fetch_seq: RTL

Program-counter register and instruction-fetch sequencer for the RISC datapath. It is the consumer end of the next-address path: it takes the address chosen by MUX C, holds it as PC, and fetches the instruction at PC from instruction memory over a request/acknowledge handshake. It presents the instruction to decode over a valid/ready handshake. It also returns PC+1 and the branch target BrA, which MUX C selects between.

---
 rtl/pc_fetch_seq_pkg.sv | 23 ++
 rtl/pc_fetch_seq_if.sv | 31 +++
 rtl/pc_branch_adder.sv | 24 ++
 rtl/pc_fetch_seq.sv | 115 +++++++++++
 4 files changed

// File: rtl/pc_fetch_seq_pkg.sv
// ==========================================================================
// pc_fetch_seq_pkg : shared FSM state type and constants for the fetch path
// Rev 1.0
// ==========================================================================
`default_nettype none

package pc_fetch_seq_pkg;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    EXEC  = 2'd3
  } state_t;

  // Top bit of the branch immediate carried in the instruction word
  localparam int IMM_MSB = 14;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_seq_if.sv
// ==========================================================================
// pc_fetch_seq_if : instruction-memory request/ack and decode valid/ready bus
// Rev 1.0
// ==========================================================================
`default_nettype none

interface pc_fetch_seq_if #(
  parameter int WIDTH = 32
);

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;
  logic [WIDTH-1:0] ir_out;
  logic             ir_valid;
  logic             ir_ready;

  modport master (
    output imem_req, imem_addr, ir_out, ir_valid,
    input  imem_ack, imem_rdata, ir_ready
  );

  modport slave (
    input  imem_req, imem_addr, ir_out, ir_valid,
    output imem_ack, imem_rdata, ir_ready
  );

endinterface

`default_nettype wire

// File: rtl/pc_branch_adder.sv
// ==========================================================================
// pc_branch_adder : PC+1 and PC+1+sext(imm) adders, shared with decode
// Rev 1.0
// ==========================================================================
`default_nettype none

module pc_branch_adder
  import pc_fetch_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [IMM_MSB:0] imm,
  output logic [WIDTH-1:0] pc_1,
  output logic [WIDTH-1:0] bra
);

  // Both sums wrap modulo 2^WIDTH by construction
  assign pc_1 = pc + WIDTH'(1);
  assign bra  = pc_1 + {{(WIDTH-IMM_MSB-1){imm[IMM_MSB]}}, imm};

endmodule

`default_nettype wire

// File: rtl/pc_fetch_seq.sv
// ==========================================================================
// pc_fetch_seq : PC register and instruction-fetch sequencer (RST/FETCH/HOLD/EXEC)
// Option macro: FETCH_TIMEOUT_EN adds a sticky fetch watchdog.  Rev 1.0
// ==========================================================================
`default_nettype none

module pc_fetch_seq
  import pc_fetch_seq_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter logic [WIDTH-1:0] RESET_PC       = WIDTH'(DEFAULT_RESET_PC),
  parameter int               TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  next_pc_in,
  input  logic              pc_load,
  pc_fetch_seq_if.master    bus,
  output logic [WIDTH-1:0]  pc_out,
  output logic [WIDTH-1:0]  pc_1_out,
  output logic [WIDTH-1:0]  bra_out,
  output logic              fetch_err
);

  state_t           state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] ir;
  logic             req;
  logic             valid;

  // req/valid are registered alongside the state so every bus output is a flop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RST;
      pc    <= RESET_PC;
      ir    <= '0;
      req   <= 1'b0;
      valid <= 1'b0;
    end else begin
      case (state)
        RST: begin
          state <= FETCH;
          req   <= 1'b1;
        end
        FETCH: begin
          if (bus.imem_ack) begin
            ir    <= bus.imem_rdata;
            req   <= 1'b0;
            valid <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.ir_ready) begin
            valid <= 1'b0;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (pc_load) begin
            pc    <= next_pc_in;
            req   <= 1'b1;
            state <= FETCH;
          end
        end
        default: state <= RST;
      endcase
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign bus.ir_out    = ir;
  assign bus.ir_valid  = valid;
  assign pc_out        = pc;

  pc_branch_adder #(
    .WIDTH (WIDTH)
  ) u_branch_adder (
    .pc   (pc),
    .imm  (ir[IMM_MSB:0]),
    .pc_1 (pc_1_out),
    .bra  (bra_out)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wdog;
  logic             err;

  // Held at zero outside FETCH, so every entry into FETCH starts a fresh count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog <= '0;
      err  <= 1'b0;
    end else if (state != FETCH || bus.imem_ack) begin
      wdog <= '0;
    end else if (wdog == CNT_LAST) begin
      wdog <= '0;
      err  <= 1'b1;
    end else begin
      wdog <= wdog + 1'b1;
    end
  end

  assign fetch_err = err;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

`default_nettype wire
